// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared core types, opcodes and the J-immediate helper
// Rev 1.0
// ============================================================================
package core_pkg;

  localparam int              XLEN             = 32;
  localparam logic [6:0]      OPC_JAL          = 7'b1101111;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } fb_entry_t;

  function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// fetch_buffer : synchronous FIFO of fetched instructions with flush
// Rev 1.0
// ============================================================================
module fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fb_entry_t              push_data,
  input  logic                   pop,
  output fb_entry_t              pop_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);

  fb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && !flush && count == FULL));
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch : PC owner, credit-limited memory fetch, JAL follow-through
// Rev 1.0
// ============================================================================
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FB_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iq_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        pred_taken,
  output logic [31:0] pred_pc
);

  localparam int            CW      = $clog2(FB_DEPTH);
  localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   ret_pc;
  logic [31:0]   jal_target;
  logic [31:0]   credit_used;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] drop;
  logic [CW:0]   fb_count;
  logic          accept;
  logic          keep;
  logic          is_jal;
  logic          pop;
  fb_entry_t     push_entry;
  fb_entry_t     head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // Occupancy plus in-flight requests never exceeds the buffer, so every response has a slot.
  assign credit_used      = 32'(fb_count) + 32'(outstanding);
  assign mem_req          = (state == ST_RUN) && (outstanding < MAX_OUT) &&
                            (credit_used < 32'(FB_DEPTH));
  assign mem_addr         = (state == ST_RUN) ? fetch_pc : '0;
  assign accept           = mem_req && mem_ready;
  assign outstanding_next = outstanding + OW'(accept) - OW'(mem_rvalid);

  assign keep       = mem_rvalid && (drop == '0) && !redirect_valid;
  assign is_jal     = keep && (mem_rdata[6:0] == OPC_JAL);
  assign jal_target = ret_pc + imm_j(mem_rdata);
  assign push_entry = {mem_rdata, ret_pc, is_jal, (is_jal ? jal_target : 32'h0)};
  assign pop        = (fb_count != '0) && !iq_full && !redirect_valid;

  fetch_buffer #(
    .DEPTH (FB_DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .flush     (redirect_valid),
    .count     (fb_count)
  );

  // Every path change discards whatever is still in flight at the end of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        ret_pc   <= {redirect_pc[31:2], 2'b00};
        drop     <= outstanding_next;
      end else if (is_jal) begin
        fetch_pc <= jal_target;
        ret_pc   <= jal_target;
        drop     <= outstanding_next;
      end else begin
        if (accept)                    fetch_pc <= fetch_pc + 32'd4;
        if (keep)                      ret_pc   <= ret_pc + 32'd4;
        if (mem_rvalid && drop != '0)  drop     <= drop - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst_out   <= '0;
      pc_out     <= '0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
    end else begin
      inst_valid <= pop;
      if (pop) begin
        inst_out   <= head.inst;
        pc_out     <= head.pc;
        pred_taken <= head.pred_taken;
        pred_pc    <= head.pred_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(mem_rvalid && outstanding == '0));
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch : scoreboard bench with in-order memory model
// Rev 1.0
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        iq_full, redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        inst_valid, pred_taken;
  logic [31:0] inst_out, pc_out, pred_pc;

  logic        w_mem_req, w_mem_rvalid, w_inst_valid, w_pred_taken;
  logic [31:0] w_mem_addr, w_inst_out, w_pc_out, w_pred_pc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .iq_full(iq_full), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out),
    .pred_taken(pred_taken), .pred_pc(pred_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .iq_full(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ready(1'b1), .mem_rvalid(w_mem_rvalid), .mem_rdata(32'h0000_0013),
    .inst_valid(w_inst_valid), .inst_out(w_inst_out), .pc_out(w_pc_out),
    .pred_taken(w_pred_taken), .pred_pc(w_pred_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Program image: sequential filler plus three JALs (+0x100, +0x100, -0x10).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h1000_006F;
      32'h140: return 32'h1000_006F;
      32'h420: return 32'hFF1F_F06F;
      default: return {a[26:2], 7'h13};
    endcase
  endfunction

  function automatic logic [31:0] jal_dest(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h120;
      32'h140: return 32'h240;
      32'h420: return 32'h410;
      default: return 32'h0;
    endcase
  endfunction

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic taken; logic [31:0] tgt; } exp_t;
  typedef struct packed { logic [31:0] addr; int due; } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  logic [31:0] model_pc;
  int          cyc = 0;
  int          lat = 1;
  int          nvalid = 0;
  int          ndel = 0;
  bit          ready_rand = 0;
  bit          redir_on_jal = 0;
  logic [31:0] redir_target = 32'h0;
  logic        last_req;
  logic [31:0] last_addr;
  logic        w_pend = 1'b0;
  logic [31:0] w_addr [3];
  logic [31:0] w_pcs [3];
  int          w_nacc = 0;
  int          w_ndel = 0;

  task automatic sb_restart(input logic [31:0] pc);
    sb.delete();
    model_pc = pc;
  endtask

  task automatic sb_fill();
    exp_t e;
    while (sb.size() < 8) begin
      e.pc    = model_pc;
      e.inst  = mem_word(model_pc);
      e.tgt   = jal_dest(model_pc);
      e.taken = (e.tgt != 32'h0);
      sb.push_back(e);
      model_pc = e.taken ? e.tgt : model_pc + 32'd4;
    end
  endtask

  task automatic cycle();
    pend_t p;
    exp_t  e;
    mem_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      p = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(p.addr);
      if (redir_on_jal && jal_dest(p.addr) != 32'h0) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
        sb_restart(redir_target & ~32'h3);
        redir_on_jal   = 0;
      end
    end
    w_mem_rvalid = w_pend;
    sb_fill();
    #1;
    last_req  = mem_req;
    last_addr = mem_addr;
    if (mem_req && mem_ready) pend.push_back('{addr: mem_addr, due: cyc + 1 + lat});
    w_pend = w_mem_req;
    if (w_mem_req && w_nacc < 3) begin
      w_addr[w_nacc] = w_mem_addr;
      w_nacc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (inst_valid) begin
      nvalid++;
      ndel++;
      if (sb.size() == 0) begin
        check("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pc", pc_out, e.pc);
        check("inst", inst_out, e.inst);
        check("pred_taken", 32'(pred_taken), 32'(e.taken));
        check("pred_pc", pred_pc, e.taken ? e.tgt : 32'h0);
      end
    end
    if (w_inst_valid && w_ndel < 3) begin
      w_pcs[w_ndel] = w_pc_out;
      w_ndel++;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend.delete();
    w_pend       = 1'b0;
    mem_rvalid   = 1'b0;
    w_mem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_pred_taken", 32'(pred_taken), 32'h0);
    check("rst_pred_pc", pred_pc, 32'h0);
    rst = 1'b0;
    sb_restart(32'h0);
  endtask

  initial begin
    rst = 1'b1; iq_full = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0; w_mem_rvalid = 1'b0;
    do_reset();

    // BOOT cycle, then the first request at address 0
    cycle();
    check("boot_no_req", 32'(last_req), 32'h0);
    cycle();
    check("first_req", 32'(last_req), 32'h1);
    check("first_addr", last_addr, 32'h0);
    cycle();
    nvalid = 0;
    repeat (8) cycle();
    check("stream_continuous", 32'(nvalid), 32'd8);
    repeat (6) cycle();   // JAL at 0x20 followed to 0x120

    // back-pressure
    iq_full = 1'b1;
    nvalid  = 0;
    repeat (10) cycle();
    check("iq_full_no_valid", 32'(nvalid), 32'h0);
    check("iq_full_req_stop", 32'(last_req), 32'h0);
    iq_full = 1'b0;
    repeat (4) cycle();

    // external redirect with two requests in flight
    lat = 3;
    repeat (6) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    sb_restart(32'h100);
    cycle();
    check("redir_bubble", 32'(inst_valid), 32'h0);
    lat = 1;
    redir_target = 32'h400;
    redir_on_jal = 1;
    for (int i = 0; i < 60 && redir_on_jal; i++) cycle();
    check("jal_redir_hit", 32'(redir_on_jal), 32'h0);
    repeat (20) cycle();

    // random ready / back-pressure
    ready_rand = 1;
    lat = 2;
    ndel = 0;
    for (int i = 0; i < 60; i++) begin
      iq_full = 1'($urandom_range(0, 1));
      cycle();
    end
    ready_rand = 0;
    iq_full = 1'b0;
    lat = 1;
    repeat (10) cycle();
    check("random_progress", 32'(ndel >= 10), 32'h1);

    // asynchronous reset in mid-stream
    check("pre_rst_valid", 32'(inst_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(inst_valid), 32'h0);
    check("async_rst_req", 32'(mem_req), 32'h0);
    do_reset();
    repeat (12) cycle();

    // wrapping fetch addresses from RESET_PC = 0xFFFF_FFF8
    check("wrap_nacc", 32'(w_nacc), 32'd3);
    check("wrap_addr0", w_addr[0], 32'hFFFF_FFF8);
    check("wrap_addr1", w_addr[1], 32'hFFFF_FFFC);
    check("wrap_addr2", w_addr[2], 32'h0000_0000);
    check("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
    check("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
    check("wrap_pc2", w_pcs[2], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
